// File: rtl/apb_add_pkg.sv
// Shared constants and types for the APB adder completer.
// Register offsets, STATUS bit positions and the transfer FSM encoding.
package apb_add_pkg;

    localparam logic [4:0] OPA_ADDR    = 5'h00;
    localparam logic [4:0] OPB_ADDR    = 5'h04;
    localparam logic [4:0] CTRL_ADDR   = 5'h08;
    localparam logic [4:0] RESULT_ADDR = 5'h0C;
    localparam logic [4:0] STATUS_ADDR = 5'h10;

    localparam int STATUS_CARRY_BIT = 0;
    localparam int STATUS_BUSY_BIT  = 1;
    localparam int STATUS_DONE_BIT  = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/apb_add_core.sv
// Operand/result registers, the 33-bit adder and the busy/done flags.
// Driven by write strobes already qualified by the bus front end.
module apb_add_core (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_opa,
    input  logic        wr_opb,
    input  logic        start,
    input  logic        clr_done,
    input  logic [31:0] wdata,
    output logic [31:0] opa,
    output logic [31:0] opb,
    output logic [31:0] result,
    output logic        carry,
    output logic        busy,
    output logic        done
);

    // NOTE: state is assigned with <= so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            opa    <= '0;
            opb    <= '0;
            result <= '0;
            carry  <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            if (wr_opa) opa <= wdata;
            if (wr_opb) opb <= wdata;
            if (clr_done) done <= 1'b0;
            // busy lasts exactly one cycle; the sum is taken on the edge that ends it
            if (busy) begin
                {carry, result} <= {1'b0, opa} + {1'b0, opb};
                busy            <= 1'b0;
                done            <= 1'b1;
            end else if (start) begin
                busy <= 1'b1;
                done <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/apb_add_slave.sv
// APB completer fronting apb_add_core: transfer FSM with optional wait
// states, address decode, error detection and registered read data.
module apb_add_slave
    import apb_add_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = 0
) (
    input  logic        pclk,
    input  logic        preset,
    input  logic        psel,
    input  logic        penable,
    input  logic [31:0] paddr,
    input  logic        pwrite,
    input  logic [31:0] pwdata,
    output logic [31:0] prdata,
    output logic        pready,
    output logic        pslverr,
    output logic        irq
);

    localparam bit         HAS_WAIT  = (WAIT_CYCLES > 0);
    localparam logic [2:0] WAIT_LOAD = 3'(HAS_WAIT ? WAIT_CYCLES - 1 : 0);

    state_t      state;
    logic [2:0]  wait_cnt;
    logic [4:0]  reg_addr;
    logic        access;
    logic        err;
    logic        commit;
    logic [31:0] rd_value;
    logic [31:0] status;
    logic [31:0] opa, opb, result;
    logic        carry, busy, done;

    assign reg_addr = paddr[4:0];
    assign access   = psel & penable;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        err = 1'b0;
        if (paddr[1:0] != 2'b00 || paddr[31:5] != '0 || reg_addr > STATUS_ADDR)
            err = 1'b1;
        if (pwrite && (reg_addr == RESULT_ADDR || reg_addr == STATUS_ADDR))
            err = 1'b1;
    end

    always_comb begin
        status                   = '0;
        status[STATUS_CARRY_BIT] = carry;
        status[STATUS_BUSY_BIT]  = busy;
        status[STATUS_DONE_BIT]  = done;
        rd_value                 = '0;
        if (!err) begin
            case (reg_addr)
                OPA_ADDR:    rd_value = opa;
                OPB_ADDR:    rd_value = opb;
                RESULT_ADDR: rd_value = result;
                STATUS_ADDR: rd_value = status;
                default:     rd_value = '0;
            endcase
        end
    end

    // A transfer only takes effect on the edge that ends RESP with the bus still held.
    assign commit = (state == RESP) && access && !err;

    // NOTE: synchronous reset clears every flop here, including the response registers.
    always_ff @(posedge pclk) begin
        if (preset) begin
            state    <= IDLE;
            wait_cnt <= '0;
            pready   <= 1'b0;
            prdata   <= '0;
            pslverr  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (access) begin
                        if (HAS_WAIT) begin
                            state    <= WAIT;
                            wait_cnt <= WAIT_LOAD;
                        end else begin
                            state   <= RESP;
                            pready  <= 1'b1;
                            prdata  <= rd_value;
                            pslverr <= err;
                        end
                    end
                end
                WAIT: begin
                    if (!access) begin
                        state <= IDLE;
                    end else if (wait_cnt == '0) begin
                        state   <= RESP;
                        pready  <= 1'b1;
                        prdata  <= rd_value;
                        pslverr <= err;
                    end else begin
                        wait_cnt <= wait_cnt - 3'd1;
                    end
                end
                RESP: begin
                    state   <= IDLE;
                    pready  <= 1'b0;
                    prdata  <= '0;
                    pslverr <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    apb_add_core u_core (
        .clk      (pclk),
        .rst      (preset),
        .wr_opa   (commit && pwrite && reg_addr == OPA_ADDR),
        .wr_opb   (commit && pwrite && reg_addr == OPB_ADDR),
        .start    (commit && pwrite && reg_addr == CTRL_ADDR && pwdata[0]),
        .clr_done (commit && !pwrite && reg_addr == RESULT_ADDR),
        .wdata    (pwdata),
        .opa      (opa),
        .opb      (opb),
        .result   (result),
        .carry    (carry),
        .busy     (busy),
        .done     (done)
    );

    assign irq = done;

endmodule

// File: tb/tb_apb_add_slave.sv
// Bench for apb_add_slave: two instances (0 and 3 wait states) driven by an
// APB master task, compared every cycle against a transaction-level model.
module tb_apb_add_slave;

    logic        clk;
    logic        preset;
    logic        psel    [2];
    logic        penable [2];
    logic        pwrite  [2];
    logic [31:0] paddr   [2];
    logic [31:0] pwdata  [2];
    logic [31:0] prdata  [2];
    logic        pready  [2];
    logic        pslverr [2];
    logic        irq     [2];

    apb_add_slave #(.WAIT_CYCLES(0)) dut0 (
        .pclk(clk), .preset(preset), .psel(psel[0]), .penable(penable[0]),
        .paddr(paddr[0]), .pwrite(pwrite[0]), .pwdata(pwdata[0]),
        .prdata(prdata[0]), .pready(pready[0]), .pslverr(pslverr[0]), .irq(irq[0])
    );

    apb_add_slave #(.WAIT_CYCLES(3)) dut3 (
        .pclk(clk), .preset(preset), .psel(psel[1]), .penable(penable[1]),
        .paddr(paddr[1]), .pwrite(pwrite[1]), .pwdata(pwdata[1]),
        .prdata(prdata[1]), .pready(pready[1]), .pslverr(pslverr[1]), .irq(irq[1])
    );

    typedef struct {
        logic [31:0] opa;
        logic [31:0] opb;
        logic [31:0] result;
        bit          carry;
        bit          busy;
        bit          done;
        longint      due;
    } model_t;

    model_t      m [2];
    bit          exp_pready [2];
    bit          exp_err    [2];
    bit          exp_rd     [2];
    logic [31:0] exp_rdata  [2];
    longint      cyc;
    bit          run;
    int          checks;
    int          errors;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic int wait_states(input int d);
        return (d == 0) ? 0 : 3;
    endfunction

    function automatic bit is_err(input logic [31:0] a, input bit w);
        return (a[1:0] != 2'b00) || (a > 32'h10) || (w && (a == 32'h0C || a == 32'h10));
    endfunction

    function automatic logic [31:0] model_read(input int d, input logic [31:0] a);
        case (a)
            32'h00:  return m[d].opa;
            32'h04:  return m[d].opb;
            32'h0C:  return m[d].result;
            32'h10:  return {29'd0, m[d].done, m[d].busy, m[d].carry};
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m[d]          = '{opa: '0, opb: '0, result: '0, carry: 0, busy: 0, done: 0, due: -1};
            exp_pready[d] = 0;
        end
    endtask

    // Sum completes one edge after the start commit.
    always @(posedge clk) begin
        #1;
        for (int d = 0; d < 2; d++) begin
            if (m[d].due == cyc) begin
                logic [32:0] s;
                s           = {1'b0, m[d].opa} + {1'b0, m[d].opb};
                m[d].result = s[31:0];
                m[d].carry  = s[32];
                m[d].busy   = 0;
                m[d].done   = 1;
                m[d].due    = -1;
            end
        end
    end

    always @(negedge clk) begin
        if (run) begin
            for (int d = 0; d < 2; d++) begin
                check($sformatf("irq%0d", d), 32'(irq[d]), 32'(m[d].done));
                check($sformatf("pready%0d", d), 32'(pready[d]), 32'(exp_pready[d]));
                if (exp_pready[d]) begin
                    check($sformatf("pslverr%0d", d), 32'(pslverr[d]), 32'(exp_err[d]));
                    if (exp_rd[d])
                        check($sformatf("prdata%0d", d), prdata[d], exp_rdata[d]);
                end
            end
        end
    end

    // mode: 0 normal, 1 drop psel right after the first access edge, 2 reset during RESP.
    // Entered and left #1 after a rising edge.
    task automatic xfer(input int d, input logic [31:0] a, input bit w, input logic [31:0] wd,
                        input int mode, output logic [31:0] rd, output logic er);
        rd         = '0;
        er         = 1'b0;
        psel[d]    = 1'b1;
        penable[d] = 1'b0;
        paddr[d]   = a;
        pwrite[d]  = w;
        pwdata[d]  = wd;
        @(posedge clk); #1;
        penable[d] = 1'b1;
        @(posedge clk); #1;
        if (mode == 1) begin
            psel[d]    = 1'b0;
            penable[d] = 1'b0;
            repeat (4) begin @(posedge clk); #1; end
            return;
        end
        repeat (wait_states(d)) begin @(posedge clk); #1; end
        exp_err[d]    = is_err(a, w);
        exp_rd[d]     = !w;
        exp_rdata[d]  = exp_err[d] ? 32'h0 : model_read(d, a);
        exp_pready[d] = 1;
        @(negedge clk);
        rd = prdata[d];
        er = pslverr[d];
        if (mode == 2) preset = 1'b1;
        @(posedge clk); #1;
        exp_pready[d] = 0;
        psel[d]       = 1'b0;
        penable[d]    = 1'b0;
        if (mode == 2) begin
            preset = 1'b0;
            model_reset();
        end else if (!exp_err[d]) begin
            if (w && a == 32'h00) m[d].opa = wd;
            if (w && a == 32'h04) m[d].opb = wd;
            if (w && a == 32'h08 && wd[0]) begin
                m[d].busy = 1;
                m[d].done = 0;
                m[d].due  = cyc + 1;
            end
            if (!w && a == 32'h0C) m[d].done = 0;
        end
    endtask

    logic [31:0] rd;
    logic        er;

    initial begin
        checks = 0;
        errors = 0;
        run    = 0;
        cyc    = 0;
        preset = 1'b1;
        for (int d = 0; d < 2; d++) begin
            psel[d] = 0; penable[d] = 0; pwrite[d] = 0; paddr[d] = '0; pwdata[d] = '0;
        end
        model_reset();
        repeat (3) @(posedge clk);
        #1 preset = 1'b0;
        run = 1;

        // Idle bus after reset.
        repeat (6) begin @(posedge clk); #1; end
        check("reset_prdata", prdata[0], 32'h0);
        check("reset_pslverr", 32'(pslverr[1]), 32'h0);

        // 5 + 7.
        xfer(0, 32'h00, 1, 32'h5, 0, rd, er);
        xfer(0, 32'h04, 1, 32'h7, 0, rd, er);
        xfer(0, 32'h08, 1, 32'h1, 0, rd, er);
        xfer(0, 32'h10, 0, 32'h0, 0, rd, er);
        check("status_done", rd, 32'h4);
        xfer(0, 32'h0C, 0, 32'h0, 0, rd, er);
        check("result_5p7", rd, 32'hC);
        xfer(0, 32'h10, 0, 32'h0, 0, rd, er);
        check("status_cleared", rd, 32'h0);

        // Carry out.
        xfer(0, 32'h00, 1, 32'hFFFF_FFFF, 0, rd, er);
        xfer(0, 32'h04, 1, 32'h2, 0, rd, er);
        xfer(0, 32'h08, 1, 32'h1, 0, rd, er);
        repeat (2) begin @(posedge clk); #1; end
        check("irq_high", 32'(irq[0]), 32'h1);
        xfer(0, 32'h10, 0, 32'h0, 0, rd, er);
        check("status_carry", rd, 32'h5);
        xfer(0, 32'h0C, 0, 32'h0, 0, rd, er);
        check("result_wrap", rd, 32'h1);
        check("irq_low", 32'(irq[0]), 32'h0);

        // Illegal accesses.
        xfer(0, 32'h14, 0, 32'h0, 0, rd, er);
        check("err_rd14", 32'(er), 32'h1);
        check("err_rd14_data", rd, 32'h0);
        xfer(0, 32'h0C, 1, 32'h1234, 0, rd, er);
        check("err_wr0c", 32'(er), 32'h1);
        xfer(0, 32'h02, 1, 32'hDEAD, 0, rd, er);
        check("err_wr02", 32'(er), 32'h1);
        xfer(0, 32'h00, 0, 32'h0, 0, rd, er);
        check("opa_kept", rd, 32'hFFFF_FFFF);
        xfer(0, 32'h0C, 0, 32'h0, 0, rd, er);
        check("result_kept", rd, 32'h1);

        // Wait states and abort in WAIT.
        xfer(1, 32'h00, 1, 32'h1234, 0, rd, er);
        xfer(1, 32'h00, 1, 32'h5555, 1, rd, er);
        xfer(1, 32'h00, 0, 32'h0, 0, rd, er);
        check("abort_opa", rd, 32'h1234);

        // Reset during RESP of a write.
        xfer(0, 32'h00, 1, 32'hAAAA, 2, rd, er);
        check("rst_pready", 32'(pready[0]), 32'h0);
        xfer(0, 32'h00, 0, 32'h0, 0, rd, er);
        check("rst_opa", rd, 32'h0);

        // Randomized traffic on both instances.
        for (int i = 0; i < 120; i++) begin
            int          d;
            int          r;
            bit          w;
            logic [31:0] a;
            logic [31:0] wd;
            d  = int'($urandom_range(0, 1));
            r  = int'($urandom_range(0, 9));
            w  = 1'($urandom_range(0, 1));
            wd = $urandom;
            if (r <= 4)      a = 32'(r * 4);
            else if (r == 5) a = 32'h14 + 32'(4 * $urandom_range(0, 3));
            else if (r == 6) a = $urandom | 32'h20;
            else if (r == 7) a = 32'(4 * $urandom_range(0, 4) + $urandom_range(1, 3));
            else begin
                a     = 32'h08;
                w     = 1'b1;
                wd[0] = 1'b1;
            end
            xfer(d, a, w, wd, 0, rd, er);
        end

        repeat (3) begin @(posedge clk); #1; end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/apb_add_slave.md
# apb_add_slave

APB completer that terminates transfers from the `apb_add_master` bus. It holds two 32-bit operand registers and a control register. It computes a registered 32-bit sum with carry, and exposes result and status through a read-only register map. Transfers can take a programmable number of wait states and report `pslverr` on illegal accesses. The block sits on the APB bus beside the master and replaces the behavioural slave currently modelled in the bench.

## Interface
- `WAIT_CYCLES`, default 0: extra access-phase wait states before `pready` is asserted. Legal range 0..7.
- `pclk` in 1: bus clock. All logic is on the rising edge.
- `preset` in 1: synchronous, active-high reset.
- `psel` in 1: slave select.
- `penable` in 1: access phase.
- `paddr` in 32: byte address. Only `paddr[4:0]` is decoded.
- `pwrite` in 1: 1 = write, 0 = read.
- `pwdata` in 32: write data.
- `prdata` out 32: read data. Registered, and valid only while `pready` = 1.
- `pready` out 1: transfer-complete strobe. Registered.
- `pslverr` out 1: error flag. Valid only while `pready` = 1.
- `irq` out 1: level copy of `STATUS.done`.

## Operation
- Register map (word-aligned):
  - 0x00 OPA: read/write.
  - 0x04 OPB: read/write.
  - 0x08 CTRL: bit0 `start` is write-1-to-trigger and reads as 0; other bits read as 0.
  - 0x0C RESULT: read-only.
  - 0x10 STATUS: read-only. bit0 `carry`, bit1 `busy`, bit2 `done`.
- Errors (`pslverr` = 1 with `pready`):
  - `paddr[1:0]` != 0.
  - `paddr` > 0x10, or any of `paddr[31:5]` nonzero.
  - A write to RESULT or STATUS.
  - An errored transfer changes no state. An errored read returns `prdata` = 0.
- Transfer FSM has three states:
  - IDLE: `pready` = 0. When `psel` & `penable` is sampled, go to WAIT if `WAIT_CYCLES` > 0 (counter loaded with `WAIT_CYCLES` − 1), otherwise go to RESP.
  - WAIT: the counter decrements each cycle. At 0, go to RESP.
  - RESP: `pready` = 1 for exactly one cycle, with `prdata` and `pslverr` driven. On the next edge the transfer commits and the FSM returns to IDLE.
- Commit: writes update the target register on the edge that ends RESP. A read of RESULT clears `done` on that same edge.
- Abort: if `psel` or `penable` deasserts in WAIT or RESP, return to IDLE with no commit.
- Adder:
  - The edge that commits a CTRL write with bit0 = 1 sets `busy` = 1 and clears `done`.
  - On the next edge: RESULT = OPA + OPB (low 32 bits), `carry` = bit 32, `busy` = 0, `done` = 1.
  - Minimum transfer spacing (3 cycles) guarantees the operands are stable while `busy` = 1.
- Sum wraps modulo 2^32. Carry is not sticky; every computation overwrites it.

## Timing
- Reset values: all registers 0; `prdata` = 0, `pready` = 0, `pslverr` = 0, `irq` = 0; FSM in IDLE.
- Reset asserted mid-transfer: everything returns to reset values on that edge, with no commit.
- Access latency: `pready` rises `WAIT_CYCLES` + 1 cycles after the first edge that samples `psel` & `penable` = 1.
  - With `WAIT_CYCLES` = 0, the access phase is 2 cycles.
- Setup phase alone (`psel` = 1, `penable` = 0) has no effect.
- Result latency: RESULT and `done` are valid 2 edges after the edge that samples the start write in RESP.
- `irq` follows `done` with no extra delay.

## Structure
- Package `apb_add_pkg` holds:
  - Register offset constants: `OPA_ADDR`, `OPB_ADDR`, `CTRL_ADDR`, `RESULT_ADDR`, `STATUS_ADDR`.
  - STATUS bit indices.
  - The FSM state enum: IDLE, WAIT, RESP.
- One natural sub-module, `apb_add_core`: operand/result registers, the adder and the busy/done flags, driven by decoded write strobes. The top level owns the FSM, address decode and error logic.

## Test plan
- Reset, then idle bus: all outputs stay 0 and `pready` never pulses.
- Write OPA = 0x0000_0005, OPB = 0x0000_0007, CTRL = 0x1, then read RESULT and STATUS:
  - RESULT = 0x0000_000C.
  - STATUS = 0x4 before the RESULT read; `done` clears after it.
- Write OPA = 0xFFFF_FFFF, OPB = 0x0000_0002, start: RESULT = 0x0000_0001 and `carry` = 1; `irq` is high until RESULT is read.
- Illegal accesses each give `pslverr` = 1 with registers unchanged:
  - read 0x14, which also returns `prdata` = 0;
  - write 0x0C;
  - write 0x02.
- `WAIT_CYCLES` = 3: `pready` rises 4 cycles after `penable` is first sampled. Dropping `psel` in WAIT leaves OPA unchanged.
- Assert `preset` during RESP of a write to OPA: OPA = 0 and `pready` = 0 on the next cycle.
